// File: rtl/kamus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kamus_pkg
// Description : Shared constants and types for the kamus front end.
// Revision    : 1.0 - initial release
// ============================================================================
package kamus_pkg;

    // addi x0,x0,0
    localparam logic [31:0] KAMUS_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/kamus_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : kamus_fetch_queue_if
// Description : IF-side push and ID-side pop channels of the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface kamus_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                       if_valid_i;
    logic [31:0]                if_instr_i;
    logic [31:0]                if_pc_i;
    logic [31:0]                if_next_pc_i;
    logic                       if_ready_o;

    logic                       id_valid_o;
    logic [31:0]                id_instr_o;
    logic [31:0]                id_pc_o;
    logic [31:0]                id_next_pc_o;
    logic                       id_ready_i;

    logic [$clog2(DEPTH):0]     count_o;

    // Environment side: IF producer and ID consumer
    modport master (
        output if_valid_i, if_instr_i, if_pc_i, if_next_pc_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_next_pc_o, count_o
    );

    // Queue side
    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, if_next_pc_i, id_ready_i,
        output if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_next_pc_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/kamus_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : kamus_fetch_queue
// Description : DEPTH-entry IF->ID decoupling FIFO with NOP on empty and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_fetch_queue
    import kamus_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = KAMUS_NOP
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    input  wire logic           flush_i,
    kamus_fetch_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("kamus_fetch_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    fetch_entry_t [DEPTH-1:0]   storage;
    fetch_entry_t               in_entry;
    fetch_entry_t               head;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = q.if_valid_i & ~full;
    assign pop   = ~empty & q.id_ready_i;

    assign in_entry = '{instr: q.if_instr_i, pc: q.if_pc_i, next_pc: q.if_next_pc_i};

    // Payload array is deliberately left unreset; only occupancy state is.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            storage[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = storage[rd_ptr];

    assign q.if_ready_o   = ~full;
    assign q.id_valid_o   = ~empty;
    assign q.count_o      = count;
    assign q.id_instr_o   = empty ? NOP_INSTR : head.instr;
    assign q.id_pc_o      = empty ? 32'h0     : head.pc;
    assign q.id_next_pc_o = empty ? 32'h0     : head.next_pc;

endmodule
`default_nettype wire
